booth_mul_seq: RTL and testbench
================================

BOOTH_MUL_SEQ -- requirements
Module: booth_mul_seq

Interface
REQ-001 Parameter WIDTH SHALL default to 32 and set the operand width; the product width SHALL be 2*WIDTH.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to multiply; sampled only while ready=1.
REQ-005 abort  input  1  synchronous cancel of an operation in progress.
REQ-006 M  input  WIDTH  signed multiplicand; captured on start acceptance.
REQ-007 Q  input  WIDTH  signed multiplier; captured on start acceptance.
REQ-008 ready  output  1  high only in IDLE.
REQ-009 busy  output  1  high in RUN and DONE.
REQ-010 done  output  1  one-cycle pulse when result becomes valid.
REQ-011 result  output  2*WIDTH  signed product; held until the next completed operation.

Function
REQ-012 The state machine SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 In IDLE with start=1 at a clock edge, the block SHALL latch M, load A=0 (WIDTH+1 bits), load the Q register with Q, clear q_m1, clear the iteration counter, and enter RUN.
REQ-014 Each RUN cycle SHALL examine {Qreg[0], q_m1}:
  - 01: A=A+sext(M).
  - 10: A=A-sext(M).
  - 00 or 11: A unchanged.
REQ-015 After the add/subtract step in the same cycle, the block SHALL arithmetic-shift-right {A, Qreg, q_m1} by one, replicating the sign bit of A.
REQ-016 A SHALL be WIDTH+1 bits wide so that M = -2^(WIDTH-1) gives correct products without overflow.
REQ-017 The iteration counter SHALL count exactly WIDTH RUN cycles; the block SHALL move from RUN to DONE at the edge that completes iteration WIDTH.
REQ-018 On entering DONE, result SHALL load {A[WIDTH-1:0], Qreg}.
REQ-019 done SHALL be 1 for exactly the single DONE cycle.
REQ-020 DONE SHALL go unconditionally to IDLE on the next edge.
REQ-021 Latency: start accepted at edge k SHALL produce done=1 in the cycle following edge k+WIDTH (k+32 by default).
REQ-022 start while busy=1 SHALL be ignored, with no effect on the operation in progress.
REQ-023 A start asserted in the DONE cycle SHALL be ignored.
REQ-024 abort=1 in RUN SHALL return to IDLE at the next edge; done SHALL NOT pulse and result SHALL be unchanged.
REQ-025 abort SHALL be ignored in IDLE and DONE.
REQ-026 If start and abort are both high in IDLE, start SHALL win.
REQ-027 Back-to-back operations: a new start SHALL be accepted in the IDLE cycle immediately after DONE.
REQ-028 result SHALL change only on entry to DONE or on reset.

Reset
REQ-029 While rst=1:
  - state=IDLE; ready=1; busy=0; done=0; result=0.
  - A, Qreg, q_m1, latched M and counter = 0.
REQ-030 rst asserted mid-RUN SHALL abandon the operation immediately, clear result to 0, and produce no done pulse.
REQ-031 After rst deasserts, the first start SHALL be accepted on the first rising edge.

Verification
REQ-032 M=3, Q=4, start at edge k -> done=1 only in the cycle after edge k+32; result=0x0000_0000_0000_000C; ready=1 one cycle later.
REQ-033 M=-1, Q=-1 -> result=0x0000_0000_0000_0001; M=-7, Q=5 -> result=0xFFFF_FFFF_FFFF_FFDD.
REQ-034 M=0x8000_0000, Q=0x8000_0000 -> result=0x4000_0000_0000_0000; M=0x7FFF_FFFF, Q=0x8000_0000 -> result=0xC000_0000_8000_0000.
REQ-035 Start M=2, Q=3, then pulse start with M=9, Q=9 during RUN -> result=6 with a single done pulse.
REQ-036 Abort at RUN cycle 10 after a prior result of 6 -> no done, result stays 6, ready=1 next cycle; a new start M=5, Q=5 then yields 25.
REQ-037 Assert rst at RUN cycle 20 -> outputs go to reset values asynchronously, with no done pulse; after release, M=-3, Q=3 -> result=0xFFFF_FFFF_FFFF_FFF7.

Source files
------------

// File: rtl/booth_mul_seq.sv
// booth_mul_seq -- sequential radix-2 Booth multiplier for signed operands.
//
// One Booth step per clock: WIDTH RUN cycles after start acceptance the
// signed 2*WIDTH-bit product is loaded into result and done pulses for
// one cycle.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   start   multiply request, sampled only while ready=1
//   abort   synchronous cancel of an operation in RUN
//   M, Q    signed multiplicand / multiplier, captured on start acceptance
//   ready   high in IDLE
//   busy    high in RUN and DONE
//   done    one-cycle pulse when result becomes valid
//   result  signed product, held until the next completed operation
module booth_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   M,
    input  logic [WIDTH-1:0]   Q,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH:0]     a_q;
    logic [WIDTH:0]     a_d;
    logic [WIDTH-1:0]   m_q;
    logic [WIDTH-1:0]   qr_q;
    logic [WIDTH-1:0]   qr_d;
    logic               qm1_q;
    logic               qm1_d;
    logic [CW-1:0]      cnt_q;
    logic               ready_q;
    logic               busy_q;
    logic               done_q;
    logic [2*WIDTH-1:0] result_q;

    // One Booth step: conditional add/subtract, then arithmetic shift of
    // {A, Qreg, q_m1}. A carries one extra bit so -2^(WIDTH-1) cannot overflow.
    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] sum;

    always_comb begin
        m_ext = {m_q[WIDTH-1], m_q};
        sum   = a_q;
        case ({qr_q[0], qm1_q})
            2'b01:   sum = a_q + m_ext;
            2'b10:   sum = a_q - m_ext;
            default: sum = a_q;
        endcase
        {a_d, qr_d, qm1_d} = {sum[WIDTH], sum, qr_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            m_q      <= '0;
            qr_q     <= '0;
            qm1_q    <= 1'b0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // start wins over abort here; abort has no meaning in IDLE
                    if (start) begin
                        m_q     <= M;
                        a_q     <= '0;
                        qr_q    <= Q;
                        qm1_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= RUN;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        a_q   <= a_d;
                        qr_q  <= qr_d;
                        qm1_q <= qm1_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST) begin
                            result_q <= {a_d[WIDTH-1:0], qr_d};
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready  = ready_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq -- self-checking bench for booth_mul_seq (WIDTH=32).
// Expected products are queued on start acceptance and compared when done
// pulses; directed sequences cover ignored starts, abort and mid-run reset.
module tb_booth_mul_seq;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           abort;
    logic [W-1:0]   M;
    logic [W-1:0]   Q;
    logic           ready;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;

    int checks     = 0;
    int errors     = 0;
    int done_count = 0;

    logic [2*W-1:0] sb[$];
    logic [2*W-1:0] sb_exp;

    typedef struct {
        logic [W-1:0]   m;
        logic [W-1:0]   q;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    booth_mul_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .abort  (abort),
        .M      (M),
        .Q      (Q),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest queued product.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_count++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 with result %h, expected no pending operation", result);
            end else begin
                sb_exp = sb.pop_front();
                check("result", result, sb_exp);
            end
        end
    end

    // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
    task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q,
                          input logic [2*W-1:0] exp, input logic with_abort);
        int n;
        M     = m;
        Q     = q;
        start = 1'b1;
        abort = with_abort;
        sb.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("busy_after_start", {63'd0, busy}, 64'd1);
        n = 1;
        while (done !== 1'b1 && n < 45) begin
            @(negedge clk);
            n++;
        end
        check("latency", 64'(n), 64'd33);
        @(negedge clk);
        check("ready_after_done", {63'd0, ready}, 64'd1);
        check("done_single_pulse", {63'd0, done}, 64'd0);
        check("result_held", result, exp);
    endtask

    initial begin
        int n;
        int dc0;
        logic [W-1:0] rm;
        logic [W-1:0] rq;

        vecs[0] = '{32'd3,          32'd4,          64'h0000_0000_0000_000C};
        vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h0000_0000_0000_0001};
        vecs[2] = '{32'hFFFF_FFF9,  32'd5,          64'hFFFF_FFFF_FFFF_FFDD};
        vecs[3] = '{32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000};
        vecs[4] = '{32'h7FFF_FFFF,  32'h8000_0000,  64'hC000_0000_8000_0000};
        for (int i = 5; i < 10; i++) begin
            rm = $urandom;
            rq = $urandom;
            vecs[i] = '{rm, rq, 64'(longint'($signed(rm)) * longint'($signed(rq)))};
        end

        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        M     = '0;
        Q     = '0;
        repeat (2) @(negedge clk);
        check("rst_ready",  {63'd0, ready}, 64'd1);
        check("rst_busy",   {63'd0, busy},  64'd0);
        check("rst_done",   {63'd0, done},  64'd0);
        check("rst_result", result,         64'd0);
        rst = 1'b0;

        // Table vectors, back-to-back; vector 2 also raises abort with start.
        for (int i = 0; i < 10; i++)
            run_op(vecs[i].m, vecs[i].q, vecs[i].exp, (i == 2));

        // start during RUN and in DONE is ignored.
        dc0   = done_count;
        M     = 32'd2;
        Q     = 32'd3;
        start = 1'b1;
        sb.push_back(64'd6);
        @(negedge clk);
        start = 1'b0;
        n = 1;
        repeat (4) begin
            @(negedge clk);
            n++;
        end
        M     = 32'd9;
        Q     = 32'd9;
        start = 1'b1;
        @(negedge clk);
        n++;
        start = 1'b0;
        while (done !== 1'b1 && n < 45) begin
            @(negedge clk);
            n++;
        end
        check("latency_ignored_start", 64'(n), 64'd33);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ready_after_done_start", {63'd0, ready}, 64'd1);
        @(negedge clk);
        check("start_in_done_ignored", {63'd0, busy}, 64'd0);
        check("single_done_pulse", 64'(done_count - dc0), 64'd1);
        check("result_six", result, 64'd6);

        // Abort at RUN cycle 10.
        dc0   = done_count;
        M     = 32'd7;
        Q     = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_ready", {63'd0, ready}, 64'd1);
        check("abort_busy",  {63'd0, busy},  64'd0);
        check("abort_result_kept", result, 64'd6);
        repeat (3) @(negedge clk);
        check("abort_no_done", 64'(done_count - dc0), 64'd0);
        check("abort_result_still", result, 64'd6);
        run_op(32'd5, 32'd5, 64'd25, 1'b0);

        // Reset at RUN cycle 20.
        dc0   = done_count;
        M     = 32'd11;
        Q     = 32'd13;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_ready",  {63'd0, ready}, 64'd1);
        check("midrst_busy",   {63'd0, busy},  64'd0);
        check("midrst_done",   {63'd0, done},  64'd0);
        check("midrst_result", result,         64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(32'hFFFF_FFFD, 32'd3, 64'hFFFF_FFFF_FFFF_FFF7, 1'b0);
        check("midrst_no_extra_done", 64'(done_count - dc0), 64'd1);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "timeout");
    end

endmodule
